// File: rtl/rr_mem_arbiter_pkg.sv
// Shared types for the I/D-cache to L2 round-robin arbiter.
// The package name is kept as rv32i_types so the rest of the core imports one type package.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    DONE_I,
    DONE_D
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_mem_arbiter_if.sv
// Bundle of the two cache-side request channels and the L2-side channel.
// Modport arb is the arbiter's view; modport tb drives the caches and the L2.
interface rr_mem_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              read_I;
  logic              write_I;
  logic [ADDR_W-1:0] addr_I;
  logic [LINE_W-1:0] wdata_I;
  logic              read_D;
  logic              write_D;
  logic [ADDR_W-1:0] addr_D;
  logic [LINE_W-1:0] wdata_D;
  logic [LINE_W-1:0] rdata_L2;
  logic              resp_L2;
  logic              read_L2;
  logic              write_L2;
  logic [ADDR_W-1:0] addr_L2;
  logic [LINE_W-1:0] wdata_L2;
  logic [LINE_W-1:0] rdata_I;
  logic [LINE_W-1:0] rdata_D;
  logic              resp_I;
  logic              resp_D;

  modport arb (
    input  read_I, write_I, addr_I, wdata_I,
    input  read_D, write_D, addr_D, wdata_D,
    input  rdata_L2, resp_L2,
    output read_L2, write_L2, addr_L2, wdata_L2,
    output rdata_I, rdata_D, resp_I, resp_D
  );

  modport tb (
    output read_I, write_I, addr_I, wdata_I,
    output read_D, write_D, addr_D, wdata_D,
    output rdata_L2, resp_L2,
    input  read_L2, write_L2, addr_L2, wdata_L2,
    input  rdata_I, rdata_D, resp_I, resp_D
  );
endinterface

// File: rtl/rr_mem_arbiter_line_reg.sv
// Generic load-enabled register with asynchronous active-low clear.
// Used to capture the line returned by L2.
module rr_mem_arbiter_line_reg #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter sharing one L2 port between the I-cache and D-cache.
// One transaction at a time; L2 sees only the latched request of the granted side.
module rr_mem_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rst,
  rr_mem_arbiter_if.arb bus
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  req_id_t           last_grant;
  req_id_t           grant;
  logic              leave_idle;
  logic              req_i;
  logic              req_d;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] line_q;
  logic              line_load;

  assign req_i = bus.read_I | bus.write_I;
  assign req_d = bus.read_D | bus.write_D;

  always_comb begin
    state_nxt  = state;
    grant      = REQ_I;
    leave_idle = 1'b0;
    case (state)
      IDLE: begin
        if (req_i && req_d) begin
          // tie: the side that did not win last time goes first
          grant = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
          grant = REQ_D;
        end else begin
          grant = REQ_I;
        end
        if (req_i || req_d) begin
          leave_idle = 1'b1;
          state_nxt  = (grant == REQ_D) ? GRANT_D : GRANT_I;
        end
      end
      GRANT_I: if (bus.resp_L2) state_nxt = DONE_I;
      GRANT_D: if (bus.resp_L2) state_nxt = DONE_D;
      DONE_I:  state_nxt = IDLE;
      DONE_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= REQ_I;
      op_wr      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (leave_idle) begin
        last_grant <= grant;
        // a simultaneous read+write from one cache resolves to a write
        if (grant == REQ_D) begin
          op_wr   <= bus.write_D;
          addr_q  <= bus.addr_D;
          wdata_q <= bus.wdata_D;
        end else begin
          op_wr   <= bus.write_I;
          addr_q  <= bus.addr_I;
          wdata_q <= bus.wdata_I;
        end
      end
    end
  end

  assign line_load = ((state == GRANT_I) || (state == GRANT_D)) && bus.resp_L2;

  rr_mem_arbiter_line_reg #(
    .WIDTH (LINE_W)
  ) u_line_reg (
    .clk  (clk),
    .rst  (rst),
    .load (line_load),
    .d    (bus.rdata_L2),
    .q    (line_q)
  );

  always_comb begin
    bus.read_L2  = 1'b0;
    bus.write_L2 = 1'b0;
    bus.addr_L2  = '0;
    bus.wdata_L2 = '0;
    bus.resp_I   = 1'b0;
    bus.resp_D   = 1'b0;
    bus.rdata_I  = '0;
    bus.rdata_D  = '0;
    case (state)
      GRANT_I, GRANT_D: begin
        bus.read_L2  = ~op_wr;
        bus.write_L2 = op_wr;
        bus.addr_L2  = addr_q;
        bus.wdata_L2 = wdata_q;
      end
      DONE_I: begin
        bus.resp_I  = 1'b1;
        bus.rdata_I = line_q;
      end
      DONE_D: begin
        bus.resp_D  = 1'b1;
        bus.rdata_D = line_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Bench for rr_mem_arbiter: directed corner cases, then randomized traffic
// scored against a round-robin reference model and an L2 responder.
module tb_rr_mem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  typedef struct {
    logic          id;
    logic [LW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rr_mem_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

  rr_mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            total = 0;
  int            bad   = 0;
  exp_t          sb[$];
  logic          model_last;
  logic [AW-1:0] cur_addr[2];
  logic [LW-1:0] cur_wdata[2];
  logic          cur_wr[2];
  bit            done_i = 1'b0;
  bit            done_d = 1'b0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int id, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [LW-1:0] w);
    if (id == 0) begin
      bus.read_I = rd; bus.write_I = wr; bus.addr_I = a; bus.wdata_I = w;
    end else begin
      bus.read_D = rd; bus.write_D = wr; bus.addr_D = a; bus.wdata_D = w;
    end
    cur_addr[id]  = a;
    cur_wdata[id] = w;
    cur_wr[id]    = wr;
  endtask

  // A cache: issue a request, hold it until its response strobe, then drop it.
  task automatic requester(input int id, input int n);
    int   gap;
    int   kind;
    logic got;
    for (int t = 0; t < n; t++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) step();
      kind = $urandom_range(0, 2);
      drive_req(id, kind != 1, kind != 0, $urandom, rand_line());
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        step();
        got = (id == 0) ? bus.resp_I : bus.resp_D;
      end
      chk($sformatf("served_%0d", id), got, 1);
      drive_req(id, 1'b0, 1'b0, '0, '0);
    end
    step();
    if (id == 0) done_i = 1'b1; else done_d = 1'b1;
  endtask

  // L2 responder plus reference arbitration: on every new L2 request decide
  // which cache should own it from who was asking in the preceding idle cycle.
  task automatic l2_model();
    logic          busy   = 1'b0;
    logic          prev_i = 1'b0;
    logic          prev_d = 1'b0;
    logic          exp_id = 1'b0;
    logic          l2;
    int            cnt    = 0;
    logic [LW-1:0] line;
    while (!(done_i && done_d)) begin
      @(negedge clk);
      bus.resp_L2 = 1'b0;
      l2 = bus.read_L2 | bus.write_L2;
      if (!busy && l2) begin
        chk("grant_had_req", prev_i | prev_d, 1);
        exp_id     = (prev_i && prev_d) ? ~model_last : prev_d;
        model_last = exp_id;
        busy       = 1'b1;
        cnt        = $urandom_range(0, 3);
      end else if (!busy && $urandom_range(0, 7) == 0) begin
        bus.rdata_L2 = rand_line();
        bus.resp_L2  = 1'b1;
      end
      if (busy) begin
        chk("l2_addr", bus.addr_L2, cur_addr[exp_id]);
        chk("l2_write", bus.write_L2, cur_wr[exp_id]);
        chk("l2_read", bus.read_L2, !cur_wr[exp_id]);
        if (cur_wr[exp_id]) chk("l2_wdata", bus.wdata_L2, cur_wdata[exp_id]);
        if (cnt == 0) begin
          line         = rand_line();
          bus.rdata_L2 = line;
          bus.resp_L2  = 1'b1;
          sb.push_back('{exp_id, line});
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end
      prev_i = bus.read_I | bus.write_I;
      prev_d = bus.read_D | bus.write_D;
    end
  endtask

  task automatic monitor();
    exp_t e;
    while (!(done_i && done_d)) begin
      @(negedge clk);
      if (bus.resp_I || bus.resp_D) begin
        chk("resp_onehot", bus.resp_I & bus.resp_D, 0);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("resp_owner", bus.resp_D, e.id);
          chk("rdata", e.id ? bus.rdata_D : bus.rdata_I, e.data);
          chk("other_rdata", e.id ? bus.rdata_I : bus.rdata_D, 0);
        end
      end else begin
        chk("quiet_rdata_I", bus.rdata_I, 0);
        chk("quiet_rdata_D", bus.rdata_D, 0);
      end
    end
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] w_d;
    logic [LW-1:0] w_i;
    logic [LW-1:0] x1;
    logic [LW-1:0] aa;
    bus.resp_L2  = 1'b0;
    bus.rdata_L2 = '0;
    drive_req(0, 1'b0, 1'b0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    w_d = rand_line();
    w_i = rand_line();
    x1  = rand_line();
    aa  = {(LW/8){8'hAA}};

    #2;
    chk("rst_read_L2", bus.read_L2, 0);
    chk("rst_write_L2", bus.write_L2, 0);
    chk("rst_resp", {bus.resp_I, bus.resp_D}, 0);
    step(); step();
    rst = 1'b1;

    // stray L2 strobe while idle
    bus.resp_L2  = 1'b1;
    bus.rdata_L2 = rand_line();
    step();
    bus.resp_L2 = 1'b0;
    chk("stray_resp", {bus.resp_I, bus.resp_D}, 0);
    chk("stray_l2", {bus.read_L2, bus.write_L2}, 0);

    // D asserts read and write together: must become a write
    drive_req(1, 1'b1, 1'b1, 32'h0000_0300, w_d);
    step();
    chk("rw_write_L2", bus.write_L2, 1);
    chk("rw_read_L2", bus.read_L2, 0);
    chk("rw_addr", bus.addr_L2, 32'h0000_0300);
    chk("rw_wdata", bus.wdata_L2, w_d);

    // asynchronous reset in the middle of the grant
    #2 rst = 1'b0;
    #1;
    chk("async_write_L2", bus.write_L2, 0);
    chk("async_addr", bus.addr_L2, 0);
    chk("async_wdata", bus.wdata_L2, 0);
    drive_req(0, 1'b1, 1'b0, 32'h0000_0200, w_i);
    #2 rst = 1'b1;

    // tie after reset: D first, then I after exactly one idle cycle
    step();
    chk("tie_d_write", bus.write_L2, 1);
    chk("tie_d_addr", bus.addr_L2, 32'h0000_0300);
    bus.resp_L2  = 1'b1;
    bus.rdata_L2 = x1;
    step();
    bus.resp_L2 = 1'b0;
    chk("done_d_resp", {bus.resp_I, bus.resp_D}, 2'b01);
    chk("done_d_rdata", bus.rdata_D, x1);
    chk("done_d_rdata_I", bus.rdata_I, 0);
    chk("done_d_l2", {bus.read_L2, bus.write_L2}, 0);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    step();
    chk("idle_gap_l2", {bus.read_L2, bus.write_L2}, 0);
    step();
    chk("i_read_L2", {bus.read_L2, bus.write_L2}, 2'b10);
    chk("i_addr", bus.addr_L2, 32'h0000_0200);
    step();
    chk("i_hold1", bus.read_L2, 1);
    step();
    chk("i_hold2", bus.read_L2, 1);
    bus.resp_L2  = 1'b1;
    bus.rdata_L2 = aa;
    step();
    bus.resp_L2 = 1'b0;
    chk("done_i_resp", {bus.resp_I, bus.resp_D}, 2'b10);
    chk("done_i_rdata", bus.rdata_I, aa);
    chk("done_i_rdata_D", bus.rdata_D, 0);
    drive_req(0, 1'b0, 1'b0, '0, '0);
    step();
    chk("back_idle", {bus.resp_I, bus.resp_D, bus.read_L2, bus.write_L2}, 0);

    // randomized contention from a clean reset
    rst = 1'b0;
    step();
    rst = 1'b1;
    model_last = 1'b0;
    fork
      requester(0, 16);
      requester(1, 16);
      l2_model();
      monitor();
    join
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
